// File: rtl/simple_dpi_pkg.sv
// Shared widths, types and the saturating-add helper for the simple_dpi datapath.
package simple_dpi_pkg;

    localparam int DATA_W  = 8;
    localparam int SHIFT_W = 3;

    typedef logic [DATA_W-1:0] data_t;

    typedef struct packed {
        data_t opt1_f;
        logic  valid;
    } param_t;

    typedef struct packed {
        logic  carry;
        data_t value;
    } sat_res_t;

    // Carry-out of a+b together with the sum clamped to all-ones on carry.
    function automatic sat_res_t sat_add(data_t a, data_t b);
        logic [DATA_W:0] sum;
        sat_res_t        res;
        sum       = {1'b0, a} + {1'b0, b};
        res.carry = sum[DATA_W];
        res.value = sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
        return res;
    endfunction

endpackage

// File: rtl/simple_dpi_alu.sv
// Combinational core: unsigned add, saturate, logical right shift and mode select.
module simple_dpi_alu
    import simple_dpi_pkg::*;
(
    input  data_t  a,
    input  data_t  b,
    input  param_t param,
    output data_t  result,
    output logic   carry
);

    sat_res_t sat;
    data_t    wrap;
    logic     shift_oob;

    always_comb begin
        sat       = sat_add(a, b);
        wrap      = a + b;
        carry     = sat.carry;
        // Shift amounts beyond the shifter range flush the result to zero.
        shift_oob = |param.opt1_f[DATA_W-1:SHIFT_W];
        result    = wrap;
        if (param.valid) begin
            if (shift_oob) begin
                result = '0;
            end else begin
                result = sat.value >> param.opt1_f[SHIFT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/simple_dpi_core.sv
// Registered add/saturate/shift block. Define SIMPLE_DPI_PARAM_REG_EN to pipeline
// the tunable parameters through shadow registers (parameter latency becomes 2).
module simple_dpi_core
    import simple_dpi_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_enable,
    input  logic [DATA_W-1:0] inputArg1,
    input  logic [DATA_W-1:0] inputArg2,
    input  logic [DATA_W-1:0] param_opt1_f,
    input  logic              param_valid,
    output logic [DATA_W-1:0] outputArg11,
    output logic              overflow
);

    param_t alu_param;
    data_t  alu_result;
    logic   alu_carry;
    data_t  result_reg;
    logic   overflow_reg;

`ifdef SIMPLE_DPI_PARAM_REG_EN
    param_t param_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            param_reg <= '0;
        end else if (clk_enable) begin
            param_reg <= '{opt1_f: param_opt1_f, valid: param_valid};
        end
    end

    assign alu_param = param_reg;
`else
    assign alu_param = '{opt1_f: param_opt1_f, valid: param_valid};
`endif

    simple_dpi_alu u_alu (
        .a      (inputArg1),
        .b      (inputArg2),
        .param  (alu_param),
        .result (alu_result),
        .carry  (alu_carry)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_reg   <= '0;
            overflow_reg <= 1'b0;
        end else if (clk_enable) begin
            result_reg   <= alu_result;
            overflow_reg <= alu_carry;
        end
    end

    assign outputArg11 = result_reg;
    assign overflow    = overflow_reg;

endmodule

// File: tb/tb_simple_dpi_core.sv
// Randomised and directed bench for simple_dpi_core against an arithmetic reference model.
module tb_simple_dpi_core;

    logic       clk;
    logic       reset;
    logic       clk_enable;
    logic [7:0] inputArg1;
    logic [7:0] inputArg2;
    logic [7:0] param_opt1_f;
    logic       param_valid;
    logic [7:0] outputArg11;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: expected outputs and the parameters the DUT will use next edge.
    logic [7:0] exp_out;
    logic       exp_ov;
    logic [7:0] sh_opt;
    logic       sh_valid;

    simple_dpi_core dut (
        .clk          (clk),
        .reset        (reset),
        .clk_enable   (clk_enable),
        .inputArg1    (inputArg1),
        .inputArg2    (inputArg2),
        .param_opt1_f (param_opt1_f),
        .param_valid  (param_valid),
        .outputArg11  (outputArg11),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_result(int a, int b, int opt, bit v);
        int s;
        int sat;
        s = a + b;
        if (!v) return s % 256;
        sat = (s > 255) ? 255 : s;
        if (opt >= 8) return 0;
        return sat / (2 ** opt);
    endfunction

    task automatic model_edge(input logic [7:0] a, b, opt, input logic v);
        logic [7:0] use_opt;
        logic       use_valid;
`ifdef SIMPLE_DPI_PARAM_REG_EN
        use_opt   = sh_opt;
        use_valid = sh_valid;
`else
        use_opt   = opt;
        use_valid = v;
`endif
        exp_out  = 8'(ref_result(int'(a), int'(b), int'(use_opt), use_valid));
        exp_ov   = (int'(a) + int'(b)) > 255;
        sh_opt   = opt;
        sh_valid = v;
    endtask

    task automatic model_reset();
        exp_out  = 8'h00;
        exp_ov   = 1'b0;
        sh_opt   = 8'h00;
        sh_valid = 1'b0;
    endtask

    // Drive one cycle of stimulus, advance past the edge, and update the model.
    task automatic step(input logic [7:0] a, b, opt, input logic v, en);
        inputArg1    = a;
        inputArg2    = b;
        param_opt1_f = opt;
        param_valid  = v;
        clk_enable   = en;
        @(posedge clk);
        if (en && reset) model_edge(a, b, opt, v);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(8'hAA, 8'h55, 8'h00, 1'b0, 1'b1);
            n_checks++;
            if (outputArg11 !== 8'h00 || overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold: out=%h ov=%b required out=00 ov=0", outputArg11, overflow);
            end
        end
        reset = 1'b1;
        step(8'hF0, 8'h20, 8'h00, 1'b0, 1'b1);
        n_checks++;
        if (outputArg11 !== 8'h10 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: out=%h ov=%b required out=10 ov=1", outputArg11, overflow);
        end
        #2 reset = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (outputArg11 !== 8'h00 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: out=%h ov=%b required out=00 ov=0", outputArg11, overflow);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_wrap();
        logic [7:0] a_tab [4] = '{8'h08, 8'h10, 8'h30, 8'h70};
        logic [7:0] b_tab [4] = '{8'h01, 8'h02, 8'h03, 8'h05};
        logic [7:0] r_tab [4] = '{8'h09, 8'h12, 8'h33, 8'h75};
        for (int i = 0; i < 4; i++) begin
            step(a_tab[i], b_tab[i], 8'h00, 1'b0, 1'b1);
            n_checks++;
            if (outputArg11 !== r_tab[i] || overflow !== 1'b0 || exp_out !== r_tab[i]) begin
                n_fail++;
                $display("FAIL wrap_%0d: out=%h ov=%b required out=%h ov=0", i, outputArg11, overflow, r_tab[i]);
            end
        end
    endtask

    task automatic test_valid_toggle();
        for (int i = 0; i < 5; i++) begin
            step(8'h70, 8'h05, 8'h00, (i % 2) == 0, 1'b1);
            n_checks++;
            if (outputArg11 !== 8'h75 || overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL valid_toggle_%0d: out=%h ov=%b required out=75 ov=0", i, outputArg11, overflow);
            end
        end
    endtask

    // Directed shift/overflow vectors; repeated once so the shadow path settles too.
    task automatic test_shift_overflow();
        logic [7:0] a_tab [8] = '{8'h70, 8'h70, 8'h08, 8'h10, 8'hF0, 8'hF0, 8'hF0, 8'hF0};
        logic [7:0] b_tab [8] = '{8'h05, 8'h05, 8'h07, 8'h08, 8'h20, 8'h20, 8'h20, 8'h20};
        logic [7:0] o_tab [8] = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h02, 8'h00, 8'h04, 8'h08};
        logic       v_tab [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [7:0] r_tab [8] = '{8'h1D, 8'h75, 8'h03, 8'h06, 8'h10, 8'hFF, 8'h0F, 8'h00};
        for (int i = 0; i < 8; i++) begin
            step(a_tab[i], b_tab[i], o_tab[i], v_tab[i], 1'b1);
            step(a_tab[i], b_tab[i], o_tab[i], v_tab[i], 1'b1);
            n_checks++;
            if (outputArg11 !== r_tab[i] || overflow !== exp_ov) begin
                n_fail++;
                $display("FAIL shift_ovf_%0d: out=%h ov=%b required out=%h ov=%b",
                         i, outputArg11, overflow, r_tab[i], exp_ov);
            end
        end
    endtask

    task automatic test_enable();
        logic [7:0] held;
        step(8'h70, 8'h05, 8'h00, 1'b1, 1'b1);
        step(8'h70, 8'h05, 8'h00, 1'b1, 1'b1);
        held = outputArg11;
        for (int i = 0; i < 3; i++) begin
            step(8'(i * 40 + 7), 8'hC3, 8'h01, 1'b0, 1'b0);
            n_checks++;
            if (outputArg11 !== held || overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL enable_hold_%0d: out=%h ov=%b required out=%h ov=0", i, outputArg11, overflow, held);
            end
        end
        // opt1_f 0 -> 2 at re-enable: 1 edge without shadow registers, 2 with them.
        step(8'h70, 8'h05, 8'h02, 1'b1, 1'b1);
        n_checks++;
        if (outputArg11 !== exp_out || overflow !== exp_ov) begin
            n_fail++;
            $display("FAIL enable_edge1: out=%h ov=%b required out=%h ov=%b", outputArg11, overflow, exp_out, exp_ov);
        end
        step(8'h70, 8'h05, 8'h02, 1'b1, 1'b1);
        n_checks++;
        if (outputArg11 !== 8'h1D) begin
            n_fail++;
            $display("FAIL enable_edge2: out=%h required out=1d", outputArg11);
        end
    endtask

    task automatic test_random();
        logic [7:0] a, b, opt;
        logic       v, en;
        for (int i = 0; i < 300; i++) begin
            a   = 8'($urandom);
            b   = 8'($urandom);
            opt = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
            v   = 1'($urandom);
            en  = ($urandom_range(0, 4) != 0);
            step(a, b, opt, v, en);
            n_checks++;
            if (outputArg11 !== exp_out || overflow !== exp_ov) begin
                n_fail++;
                $display("FAIL random_%0d: a=%h b=%h opt=%h v=%b en=%b out=%h ov=%b required out=%h ov=%b",
                         i, a, b, opt, v, en, outputArg11, overflow, exp_out, exp_ov);
            end
        end
    endtask

    initial begin
        reset        = 1'b0;
        clk_enable   = 1'b0;
        inputArg1    = 8'h00;
        inputArg2    = 8'h00;
        param_opt1_f = 8'h00;
        param_valid  = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_wrap();
        test_valid_toggle();
        test_shift_overflow();
        test_enable();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/simple_dpi_core.md
Name: simple_dpi_core

Overview:
8-bit two-operand arithmetic datapath with two runtime-tunable parameters: an option word (opt1_f) and a mode bit (valid).
- Adds inputArg1 and inputArg2 and registers the result on outputArg11.
- In valid mode the sum saturates and is right-shifted by opt1_f.
- Sits as a leaf compute block behind a clock-enabled pipeline stage; parameters are driven by a host/config block.

Parameters:
DATA_W, 8, width of inputArg1, inputArg2, outputArg11 and param_opt1_f.
SHIFT_W, 3, number of low bits of param_opt1_f used as shift amount.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = in reset)
clk_enable  input  1  clock enable; 0 freezes all state
inputArg1  input  DATA_W  operand A, unsigned
inputArg2  input  DATA_W  operand B, unsigned
param_opt1_f  input  DATA_W  tunable option word (shift amount)
param_valid  input  1  tunable mode bit
outputArg11  output  DATA_W  registered result
overflow  output  1  registered carry-out of A+B

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on port reset.
- While reset=0: outputArg11=0, overflow=0, and any parameter registers=0. Reset deassertion is synchronised by the integrating block.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.
- All state updates only on a rising clk edge with reset=1 and clk_enable=1. With clk_enable=0 every register holds.
- Sum: sum = {0,A} + {0,B}, DATA_W+1 bits, unsigned.
- Saturated sum: sat = all-ones if sum[DATA_W]=1, else sum[DATA_W-1:0].
- Mode valid=0: outputArg11 <= sum[DATA_W-1:0] (wrap-around). opt1_f is ignored.
- Mode valid=1: outputArg11 <= sat >> opt1_f[SHIFT_W-1:0] (logical shift).
  - If any bit of opt1_f above SHIFT_W-1 is set, result = 0.
- overflow <= sum[DATA_W] in both modes.
- Latency: 1 enabled clock from inputs/parameters to outputs. No handshake; a new result every enabled cycle.
- Parameter changes take effect on the next enabled edge; no glitch handling is required.
- X on inputs before first drive may propagate to outputs. Reset values stay defined.

Optional Feature:
- Macro: SIMPLE_DPI_PARAM_REG_EN.
- Defined:
  - param_opt1_f and param_valid are captured in shadow registers on each enabled edge (reset value 0).
  - The datapath uses the shadow copies, so parameter-to-output latency is 2 enabled cycles.
  - Data latency stays 1 cycle.
- Undefined: parameters feed the datapath combinationally; parameter-to-output latency is 1 cycle.

Decomposition:
- Package simple_dpi_pkg holds:
  - DATA_W and SHIFT_W defaults;
  - typedef data_t (logic [DATA_W-1:0]);
  - typedef param_t, a struct {data_t opt1_f; logic valid;};
  - function sat_add(data_t a, data_t b) returning the {carry, saturated value} pair.
- One natural sub-module: simple_dpi_alu. Purely combinational: sum, saturate, shift, mode mux.
- Top simple_dpi_core holds the registers, the enable/reset logic and the optional shadow registers.

Test Plan:
1. Hold reset=0 for 2 cycles with inputs 0xAA/0x55 -> outputArg11=0x00 and overflow=0 throughout. Assert reset=0 mid-stream -> outputs drop to 0 before the next clk edge.
2. valid=0, clk_enable=1: A=0x08,B=0x01 -> 0x09; A=0x10,B=0x02 -> 0x12; A=0x30,B=0x03 -> 0x33; A=0x70,B=0x05 -> 0x75. Each appears one enabled edge after being applied; overflow=0.
3. valid=1, opt1_f=0x00, A=0x70,B=0x05 -> 0x75. Toggle valid 1/0/1/0 each cycle -> output stays 0x75 (both modes agree when there is no overflow and no shift).
4. opt1_f=0x02, valid=1, A=0x70,B=0x05 -> 0x1D; valid=0 -> 0x75. A=0x08,B=0x07 with valid=1 -> 0x03; A=0x10,B=0x08 with valid=1 -> 0x06.
5. Overflow with A=0xF0,B=0x20: valid=0 -> 0x10 with overflow=1; valid=1, opt1_f=0 -> 0xFF; opt1_f=0x04 -> 0x0F; opt1_f=0x08 -> 0x00.
6. clk_enable=0 for 3 cycles while inputs change -> outputs hold their last values. Re-enable -> update after one edge.
   - Under SIMPLE_DPI_PARAM_REG_EN, an opt1_f change from 0 to 2 reaches the output after 2 enabled edges.
